rv_pipe_controller: RTL and testbench
=====================================

# rv_pipe_controller

Parametrised successor to the single-cycle RV32I decoder for the 3-stage core. It decodes the instruction in the decode/execute stage, registers writeback controls into the memory/writeback stage, and handles branch flush and external stall. It flags illegal encodings. Optionally it sequences multi-cycle M-extension operations with a busy interlock toward fetch.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles a MUL-class op occupies the execute stage (≥1).
- `DIV_LAT`, default 32: cycles a DIV/REM-class op occupies the execute stage (≥1).
- `ALU_OP_W`, default 5: width of the ALU operation code.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instruction`  in  32  instruction in decode/execute stage.
- `instr_valid`  in  1  `instruction` holds a real instruction.
- `br_taken`  in  1  branch comparator result for the current instruction.
- `stall`  in  1  external hold (data memory not ready).
- `select_A`, `select_B`  out  1  ALU operand selects (comb).
- `immediate_source`  out  3  immediate format (comb).
- `function_code`  out  3  instr[14:12] (comb).
- `alu_operation`  out  ALU_OP_W  ALU/MDU op (comb).
- `PC_src`  out  1  redirect fetch (comb).
- `busy`  out  1  hold fetch and decode (comb).
- `illegal`  out  1  current instruction is illegal (comb).
- `reg_write_q`  out  1  stage-2 register-file write enable.
- `write_back_select_q`  out  2  stage-2 writeback mux select.
- `rd_q`  out  5  stage-2 destination register.
- `wb_valid_q`  out  1  stage 2 holds a valid instruction.
- `illegal_q`  out  1  stage-2 illegal-instruction flag.

## Operation
- Decodes R, I-ALU, load, S, B, LUI, AUIPC, JAL and JALR. Every combinational output has a default, so no don't-cares and no latches.
- Unknown opcode, or funct7 not in {0000000, 0100000} where funct7 matters, sets `illegal`=1. In that case reg_write is forced to 0 and alu_operation is ADD.
- `PC_src` = valid_eff & ((B-type & `br_taken`) | JAL | JALR).
- valid_eff = `instr_valid` & ~flush_q.
- flush_q is set the cycle after `PC_src`=1 with `stall`=0. While set, the next decoded instruction becomes a bubble. It clears after one cycle.
- Stage-2 update on each cycle with `stall`=0 and `busy`=0:
  - wb_valid_q ← valid_eff.
  - reg_write_q ← decoded & valid_eff & ~illegal.
  - write_back_select_q and rd_q ← decoded values.
  - illegal_q ← illegal & valid_eff.
- `stall`=1: all stage-2 registers and flush_q hold their values.
- `busy`=1 without completion: stage 2 receives a bubble (wb_valid_q=0, reg_write_q=0).
- Reset values: every registered output is 0, flush_q is 0, FSM is IDLE, counter is 0.
- Combinational outputs follow `instruction` with no reset dependence.

## Timing
- Decode outputs are valid in the same cycle. Stage-2 outputs lag by exactly one cycle.
- MDU FSM (present only with the macro):
  - IDLE→BUSY when a valid M-op is present and `stall`=0. The counter loads LAT−1 (MUL_LAT for funct3[2]=0, DIV_LAT for funct3[2]=1).
  - In BUSY, the counter decrements each cycle, independent of `stall`.
  - In BUSY with counter 0 and `stall`=0: completion. Stage 2 captures the M-op and the FSM returns to IDLE.
  - In BUSY with counter 0 and `stall`=1: the FSM holds in BUSY.
- `busy` = (IDLE & M-op accept) | (BUSY & counter≠0). It is high for exactly LAT cycles starting with the accept cycle. wb_valid_q rises at cycle LAT+1.
- LAT=1: accept in cycle 0, complete in cycle 1.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1). The counter never wraps.
- `rst_n`=0 mid-BUSY: the FSM returns to IDLE, the counter clears and `busy` drops the next cycle. The in-flight M-op is discarded.

## Configuration
- `RV_CTRL_MEXT_EN` defined:
  - R-type with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
  - The MDU FSM and `busy` interlock are present.
- `RV_CTRL_MEXT_EN` undefined:
  - funct7=0000001 is illegal.
  - `busy` is tied to 0 and no FSM or counter is instantiated.
  - MUL_LAT and DIV_LAT are ignored.

## Structure
- Shared package `rv_ctrl_pkg`:
  - alu_op_e enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI=10, MUL..REMU=11..18.
  - Opcode constants.
  - imm_src constants: I=0, S=1, B=2, J=3, U=4.
  - wb_sel constants: PC+4=0, ALU=1, MEM=2.
- One sub-module, `rv_mdu_sequencer`, contains the FSM and counter. It is instantiated only under the macro.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → all `_q` outputs are 0 and `busy`=0.
- Basic decode: `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3):
  - alu_operation is 0 and then 1.
  - A cycle later, reg_write_q=1, rd_q=3, write_back_select_q=1.
- Illegal: R-type with funct7=0000010 → `illegal`=1, then illegal_q=1 and reg_write_q=0.
- Taken branch: `beq` with `br_taken`=1 → `PC_src`=1. The following `addi` is bubbled (wb_valid_q=0 one cycle later).
- With `RV_CTRL_MEXT_EN` and DIV_LAT=4:
  - `div x5,x6,x7` → `busy` is high for cycles 0–3 and wb_valid_q=1 with rd_q=5 at cycle 5.
  - `stall`=1 at cycle 4 delays completion by one cycle.
- Reset mid-op: pulse `rst_n`=0 at cycle 2 of the DIV → `busy`=0 next cycle and no writeback occurs.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv_ctrl_pkg
// Brief    : Shared encodings and decode helpers for the RV32I pipe controller.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT = 7'b0000001;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_J = 3'd3;
    localparam logic [2:0] c_IMM_U = 3'd4;

    localparam logic [1:0] c_WB_PC4 = 2'd0;
    localparam logic [1:0] c_WB_ALU = 2'd1;
    localparam logic [1:0] c_WB_MEM = 2'd2;

    typedef struct packed {
        logic       sel_a;
        logic       sel_b;
        logic [2:0] imm_src;
        alu_op_e    alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
    } dec_t;

    function automatic logic f7_is_base(input logic [6:0] f7);
        return (f7 == c_F7_BASE) || (f7 == c_F7_ALT);
    endfunction

    function automatic logic f7_is_mext(input logic [6:0] f7);
        return (f7 == c_F7_MEXT);
    endfunction

    // alt selects SUB/SRA; it is only meaningful for funct3 000 and 101
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e mdu_alu_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rv_mdu_sequencer
// Brief    : Holds a multi-cycle MUL/DIV op in execute and drives the busy interlock.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mdu_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_mop_valid,
    input  logic i_is_div,
    input  logic i_stall,
    output logic o_busy
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter runs regardless of stall; only the final hand-off waits for it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (i_mop_valid && !i_stall) begin
                    o_busy      = 1'b1;
                    w_state_nxt = c_S_BUSY;
                    w_cnt_nxt   = i_is_div ? c_DIV_LOAD : c_MUL_LOAD;
                end
            end
            c_S_BUSY: begin
                if (r_cnt != '0) begin
                    o_busy    = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!i_stall) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : rv_pipe_controller
// Brief    : RV32I decode, stage-2 writeback controls, branch flush and stall.
// Options  : RV_CTRL_MEXT_EN adds M-extension decode and the MDU busy interlock.
// Revision : 1.0 - initial release
// ============================================================================
module rv_pipe_controller #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instruction,
    input  logic                instr_valid,
    input  logic                br_taken,
    input  logic                stall,
    output logic                select_A,
    output logic                select_B,
    output logic [2:0]          immediate_source,
    output logic [2:0]          function_code,
    output logic [ALU_OP_W-1:0] alu_operation,
    output logic                PC_src,
    output logic                busy,
    output logic                illegal,
    output logic                reg_write_q,
    output logic [1:0]          write_back_select_q,
    output logic [4:0]          rd_q,
    output logic                wb_valid_q,
    output logic                illegal_q
);

    import rv_ctrl_pkg::*;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    dec_t       w_dec;
    logic       w_valid_eff;
    logic       w_pc_src;
    logic       w_busy;
    logic       w_unused_rs;

    logic       r_flush;
    logic       r_reg_write;
    logic [1:0] r_wb_sel;
    logic [4:0] r_rd;
    logic       r_wb_valid;
    logic       r_illegal;

    assign w_opcode    = instruction[6:0];
    assign w_funct3    = instruction[14:12];
    assign w_funct7    = instruction[31:25];
    assign w_unused_rs = ^instruction[24:15];

`ifdef RV_CTRL_MEXT_EN
    logic w_is_mop;
    logic w_mop_valid;
`endif

    always_comb begin
        w_dec = '{sel_a: 1'b0, sel_b: 1'b0, imm_src: c_IMM_I, alu_op: ALU_ADD,
                  reg_write: 1'b0, wb_sel: c_WB_PC4, is_branch: 1'b0,
                  is_jump: 1'b0, illegal: 1'b0};
`ifdef RV_CTRL_MEXT_EN
        w_is_mop = 1'b0;
`endif
        case (w_opcode)
            c_OPC_OP: begin
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel    = c_WB_ALU;
                if (f7_is_base(w_funct7)) begin
                    w_dec.alu_op = base_alu_op(w_funct3, w_funct7[5]);
                end
`ifdef RV_CTRL_MEXT_EN
                else if (f7_is_mext(w_funct7)) begin
                    w_dec.alu_op = mdu_alu_op(w_funct3);
                    w_is_mop     = 1'b1;
                end
`endif
                else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                w_dec.sel_b     = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel    = c_WB_ALU;
                // funct7 only exists for the shift-immediate forms
                if (w_funct3[1:0] == 2'b01 && !f7_is_base(w_funct7)) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.alu_op = base_alu_op(w_funct3,
                                               (w_funct3 == 3'b101) & w_funct7[5]);
                end
            end
            c_OPC_LOAD: begin
                w_dec.sel_b     = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel    = c_WB_MEM;
            end
            c_OPC_STORE: begin
                w_dec.sel_b   = 1'b1;
                w_dec.imm_src = c_IMM_S;
            end
            c_OPC_BRANCH: begin
                w_dec.sel_a     = 1'b1;
                w_dec.sel_b     = 1'b1;
                w_dec.imm_src   = c_IMM_B;
                w_dec.is_branch = 1'b1;
            end
            c_OPC_LUI: begin
                w_dec.sel_b     = 1'b1;
                w_dec.imm_src   = c_IMM_U;
                w_dec.alu_op    = ALU_LUI;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel    = c_WB_ALU;
            end
            c_OPC_AUIPC: begin
                w_dec.sel_a     = 1'b1;
                w_dec.sel_b     = 1'b1;
                w_dec.imm_src   = c_IMM_U;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel    = c_WB_ALU;
            end
            c_OPC_JAL: begin
                w_dec.sel_a     = 1'b1;
                w_dec.sel_b     = 1'b1;
                w_dec.imm_src   = c_IMM_J;
                w_dec.reg_write = 1'b1;
                w_dec.is_jump   = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.sel_b     = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.is_jump   = 1'b1;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.alu_op    = ALU_ADD;
        end
    end

    assign w_valid_eff = instr_valid & ~r_flush;
    assign w_pc_src    = w_valid_eff & ((w_dec.is_branch & br_taken) | w_dec.is_jump);

`ifdef RV_CTRL_MEXT_EN
    assign w_mop_valid = w_valid_eff & w_is_mop;

    rv_mdu_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mop_valid (w_mop_valid),
        .i_is_div    (w_funct3[2]),
        .i_stall     (stall),
        .o_busy      (w_busy)
    );
`else
    logic [31:0] w_unused_lat;
    assign w_unused_lat = 32'(MUL_LAT + DIV_LAT);
    assign w_busy       = 1'b0;
`endif

    // Stall freezes everything; busy injects bubbles until the M-op completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wb_sel    <= 2'd0;
            r_rd        <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_flush <= w_pc_src;
            if (w_busy) begin
                r_wb_valid  <= 1'b0;
                r_reg_write <= 1'b0;
                r_illegal   <= 1'b0;
            end else begin
                r_wb_valid  <= w_valid_eff;
                r_reg_write <= w_dec.reg_write & w_valid_eff;
                r_wb_sel    <= w_dec.wb_sel;
                r_rd        <= instruction[11:7];
                r_illegal   <= w_dec.illegal & w_valid_eff;
            end
        end
    end

    assign select_A            = w_dec.sel_a;
    assign select_B            = w_dec.sel_b;
    assign immediate_source    = w_dec.imm_src;
    assign function_code       = w_funct3;
    assign alu_operation       = ALU_OP_W'(w_dec.alu_op);
    assign PC_src              = w_pc_src;
    assign busy                = w_busy;
    assign illegal             = w_dec.illegal;
    assign reg_write_q         = r_reg_write;
    assign write_back_select_q = r_wb_sel;
    assign rd_q                = r_rd;
    assign wb_valid_q          = r_wb_valid;
    assign illegal_q           = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_pipe_controller
// Brief    : Directed vector table plus M-extension sequences (RV_CTRL_MEXT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_pipe_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        br_taken;
    logic        stall;
    logic        select_A;
    logic        select_B;
    logic [2:0]  immediate_source;
    logic [2:0]  function_code;
    logic [4:0]  alu_operation;
    logic        PC_src;
    logic        busy;
    logic        illegal;
    logic        reg_write_q;
    logic [1:0]  write_back_select_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic        illegal_q;

    int n_total = 0;
    int n_pass  = 0;

    rv_pipe_controller #(
        .MUL_LAT  (2),
        .DIV_LAT  (4),
        .ALU_OP_W (5)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction         (instruction),
        .instr_valid         (instr_valid),
        .br_taken            (br_taken),
        .stall               (stall),
        .select_A            (select_A),
        .select_B            (select_B),
        .immediate_source    (immediate_source),
        .function_code       (function_code),
        .alu_operation       (alu_operation),
        .PC_src              (PC_src),
        .busy                (busy),
        .illegal             (illegal),
        .reg_write_q         (reg_write_q),
        .write_back_select_q (write_back_select_q),
        .rd_q                (rd_q),
        .wb_valid_q          (wb_valid_q),
        .illegal_q           (illegal_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        br;
        logic        stl;
        logic [4:0]  alu;
        logic        ill;
        logic        pcs;
        logic        chk_imm;
        logic [2:0]  imm;
        logic        wbv;
        logic        rw;
        logic        chk_sel;
        logic [1:0]  wbs;
        logic [4:0]  rd;
        logic        illq;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_BADR = 32'h042081B3;
    localparam logic [31:0] I_XOR  = 32'h0062C233;
    localparam logic [31:0] I_SRA  = 32'h409453B3;
    localparam logic [31:0] I_ADDI = 32'h00500513;
    localparam logic [31:0] I_SRAI = 32'h40365593;
    localparam logic [31:0] I_BADI = 32'h02109093;
    localparam logic [31:0] I_LW   = 32'h00812683;
    localparam logic [31:0] I_SW   = 32'h00E12623;
    localparam logic [31:0] I_LUI  = 32'h123457B7;
    localparam logic [31:0] I_AUI  = 32'h00001817;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_JALR = 32'h00008067;
    localparam logic [31:0] I_UNK  = 32'h0000007F;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h027342B3;

    function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic br,
                                input logic stl, input logic [4:0] alu, input logic ill,
                                input logic pcs, input logic chk_imm, input logic [2:0] imm,
                                input logic wbv, input logic rw, input logic chk_sel,
                                input logic [1:0] wbs, input logic [4:0] rd, input logic illq);
        vec_t v;
        v.instr = instr; v.valid = valid; v.br = br; v.stl = stl;
        v.alu = alu; v.ill = ill; v.pcs = pcs; v.chk_imm = chk_imm; v.imm = imm;
        v.wbv = wbv; v.rw = rw; v.chk_sel = chk_sel; v.wbs = wbs; v.rd = rd; v.illq = illq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic br, input logic s);
        instruction = ins; instr_valid = v; br_taken = br; stall = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] w;
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wb_valid_q", wb_valid_q, 0);
        chk("rst reg_write_q", reg_write_q, 0);
        chk("rst wb_sel_q", write_back_select_q, 0);
        chk("rst rd_q", rd_q, 0);
        chk("rst illegal_q", illegal_q, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1;

        //          instr   v  br st alu ill pcs ci imm wbv rw cs wbs rd illq
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 3,  0));
        vecs.push_back(mk(I_SUB,  1, 0, 0, 1,  0, 0, 0, 0, 1, 1, 1, 1, 3,  0));
        vecs.push_back(mk(I_BADR, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 3,  1));
        vecs.push_back(mk(I_XOR,  1, 0, 0, 5,  0, 0, 0, 0, 1, 1, 1, 1, 4,  0));
        vecs.push_back(mk(I_SRA,  1, 0, 0, 7,  0, 0, 0, 0, 1, 1, 1, 1, 7,  0));
        vecs.push_back(mk(I_ADDI, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 1, 1, 10, 0));
        vecs.push_back(mk(I_SRAI, 1, 0, 0, 7,  0, 0, 1, 0, 1, 1, 1, 1, 11, 0));
        vecs.push_back(mk(I_BADI, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 1,  1));
        vecs.push_back(mk(I_LW,   1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 1, 2, 13, 0));
        vecs.push_back(mk(I_SW,   1, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0, 0, 12, 0));
        vecs.push_back(mk(I_LUI,  1, 0, 0, 10, 0, 0, 1, 4, 1, 1, 1, 1, 15, 0));
        vecs.push_back(mk(I_AUI,  1, 0, 0, 0,  0, 0, 1, 4, 1, 1, 1, 1, 16, 0));
        vecs.push_back(mk(I_BEQ,  1, 0, 0, 0,  0, 0, 1, 2, 1, 0, 0, 0, 8,  0));
        vecs.push_back(mk(I_BEQ,  1, 1, 0, 0,  0, 1, 1, 2, 1, 0, 0, 0, 8,  0));
        vecs.push_back(mk(I_ADDI, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 1, 10, 0));
        vecs.push_back(mk(I_JAL,  1, 0, 0, 0,  0, 1, 1, 3, 1, 1, 1, 0, 1,  0));
        vecs.push_back(mk(I_JALR, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 0, 0,  0));
        vecs.push_back(mk(I_JALR, 1, 0, 0, 0,  0, 1, 1, 0, 1, 1, 1, 0, 0,  0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 3,  0));
        vecs.push_back(mk(I_UNK,  1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 0,  1));
        vecs.push_back(mk(I_UNK,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        vecs.push_back(mk(I_ADD,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 3,  0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 3,  0));
        vecs.push_back(mk(I_JAL,  1, 0, 1, 0,  0, 1, 1, 3, 1, 1, 1, 1, 3,  0));
        vecs.push_back(mk(I_XOR,  1, 0, 0, 5,  0, 0, 0, 0, 1, 1, 1, 1, 4,  0));
        vecs.push_back(mk(I_BEQ,  1, 1, 1, 0,  0, 1, 1, 2, 1, 1, 1, 1, 4,  0));
        vecs.push_back(mk(I_BEQ,  1, 1, 0, 0,  0, 1, 1, 2, 1, 0, 0, 0, 8,  0));
        vecs.push_back(mk(I_ADD,  1, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0, 8,  0));
        vecs.push_back(mk(I_JAL,  1, 0, 0, 0,  0, 0, 1, 3, 0, 0, 1, 0, 1,  0));
        vecs.push_back(mk(I_ADD,  1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 3,  0));
`ifndef RV_CTRL_MEXT_EN
        vecs.push_back(mk(I_MUL,  1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 3,  1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            w = v.instr;
            drive(v.instr, v.valid, v.br, v.stl);
            #1;
            chk($sformatf("row%0d alu_operation", i), alu_operation, v.alu);
            chk($sformatf("row%0d illegal", i), illegal, v.ill);
            chk($sformatf("row%0d PC_src", i), PC_src, v.pcs);
            chk($sformatf("row%0d busy", i), busy, 0);
            chk($sformatf("row%0d function_code", i), function_code, w[14:12]);
            if (v.chk_imm) chk($sformatf("row%0d immediate_source", i), immediate_source, v.imm);
            step();
            chk($sformatf("row%0d wb_valid_q", i), wb_valid_q, v.wbv);
            chk($sformatf("row%0d reg_write_q", i), reg_write_q, v.rw);
            chk($sformatf("row%0d rd_q", i), rd_q, v.rd);
            chk($sformatf("row%0d illegal_q", i), illegal_q, v.illq);
            if (v.chk_sel) chk($sformatf("row%0d wb_sel_q", i), write_back_select_q, v.wbs);
        end

`ifdef RV_CTRL_MEXT_EN
        // MUL, latency 2
        drive(I_MUL, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mul alu", alu_operation, 11);
        chk("mul illegal", illegal, 0);
        chk("mul busy c0", busy, 1);
        step();
        chk("mul busy c1", busy, 1);
        chk("mul wbv c1", wb_valid_q, 0);
        step();
        chk("mul busy c2", busy, 0);
        chk("mul wbv c2", wb_valid_q, 0);
        step();
        chk("mul wbv c3", wb_valid_q, 1);
        chk("mul rd c3", rd_q, 3);
        chk("mul rw c3", reg_write_q, 1);
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        step();

        // DIV, latency 4, no stall
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        #1;
        chk("div alu", alu_operation, 15);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("div busy c%0d", c), busy, (c < 4) ? 1 : 0);
            if (c > 0) chk($sformatf("div wbv c%0d", c), wb_valid_q, 0);
            step();
        end
        chk("div wbv c5", wb_valid_q, 1);
        chk("div rd c5", rd_q, 5);
        chk("div rw c5", reg_write_q, 1);
        chk("div wbsel c5", write_back_select_q, 1);
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        step();

        // DIV with stall in cycle 4
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("divst busy c%0d", c), busy, 1);
            step();
        end
        stall = 1'b1;
        #1;
        chk("divst busy c4", busy, 0);
        chk("divst wbv c4", wb_valid_q, 0);
        step();
        stall = 1'b0;
        #1;
        chk("divst busy c5", busy, 0);
        chk("divst wbv c5", wb_valid_q, 0);
        step();
        chk("divst wbv c6", wb_valid_q, 1);
        chk("divst rd c6", rd_q, 5);
        drive(I_ADD, 1'b1, 1'b0, 1'b0);
        step();

        // DIV aborted by reset in cycle 2
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        #1;
        chk("divrst busy c0", busy, 1);
        step();
        chk("divrst busy c1", busy, 1);
        step();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        step();
        chk("divrst busy c3", busy, 0);
        chk("divrst wbv c3", wb_valid_q, 0);
        rst_n = 1'b1;
        for (int c = 4; c < 8; c++) begin
            #1;
            chk($sformatf("divrst busy c%0d", c), busy, 0);
            chk($sformatf("divrst wbv c%0d", c), wb_valid_q, 0);
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
